// File: rtl/sw_pkg.sv
// Stopwatch controller shared definitions: FSM state encodings and display width.
// Imported by key_filter and stopwatch_ctrl.
package sw_pkg;

    localparam int DISP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

endpackage

// File: rtl/key_filter.sv
// Key debouncer: 2-FF synchroniser, low-time counter and one-shot flag.
// Ports: sys_clk, sys_rst_n (async, active-low), key_in_n (raw key, active-low),
//        key_flag (1-cycle pulse once the key has been stably low for CNT_MAX+1 cycles).
module key_filter
    import sw_pkg::*;
#(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in_n,
    output logic key_flag
);

    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_cnt;
    logic        r_done;
    logic        w_low;
    logic        w_hit;

    assign w_low = ~r_sync2;
    // r_done blocks repeats while the key stays held
    assign w_hit = w_low && (r_cnt == CNT_MAX) && !r_done;
    assign key_flag = w_hit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_sync1 <= key_in_n;
            r_sync2 <= r_sync1;
            if (!w_low) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 20'd1;
                end
                if (w_hit) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced keys -> start level, clear pulse, lap freeze.
// Ports: sys_clk, sys_rst_n, key_ss_n, key_lap_n, key_clr_n, data_live[15:0] in;
//        start_signal, clear_signal, data_disp[15:0], lap_hold, state_o[1:0] out.
// Optional feature macro: LAP_EN (lap key, LAP state and lap register).
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter logic [19:0]       CNT_20MS   = 20'd999_999,
    parameter logic [DISP_W-1:0] DATA_LIMIT = 16'd9999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_ss_n,
    input  logic              key_lap_n,
    input  logic              key_clr_n,
    input  logic [DISP_W-1:0] data_live,
    output logic              start_signal,
    output logic              clear_signal,
    output logic [DISP_W-1:0] data_disp,
    output logic              lap_hold,
    output logic [1:0]        state_o
);

    sw_state_e r_state;
    sw_state_e w_nxt;
    logic      w_ss;
    logic      w_clr;
    logic      w_lap;
    logic      w_limit;
    logic      w_clr_go;
    logic      w_lap_cap;
    logic      w_start_d;
    logic      r_start;
    logic      r_clear;

    key_filter #(.CNT_MAX(CNT_20MS)) u_ss (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in_n  (key_ss_n),
        .key_flag  (w_ss)
    );

    key_filter #(.CNT_MAX(CNT_20MS)) u_clr (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in_n  (key_clr_n),
        .key_flag  (w_clr)
    );

`ifdef LAP_EN
    logic              w_hold_d;
    logic              r_lap_hold;
    logic [DISP_W-1:0] r_lap;

    key_filter #(.CNT_MAX(CNT_20MS)) u_lap (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in_n  (key_lap_n),
        .key_flag  (w_lap)
    );
`else
    logic w_unused_lap;
    assign w_unused_lap = key_lap_n;
    assign w_lap = 1'b0;
`endif

    assign w_limit = (data_live >= DATA_LIMIT);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // clr outranks ss outranks lap; a masked pulse is dropped even
    // when the higher one is ignored in the current state
    always_comb begin
        w_nxt     = r_state;
        w_clr_go  = 1'b0;
        w_lap_cap = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_clr) begin
                    w_clr_go = 1'b1;
                end else if (w_ss) begin
                    w_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_limit) begin
                    w_nxt = ST_PAUSE;
                end else if (w_clr) begin
                    w_nxt = ST_RUN;
                end else if (w_ss) begin
                    w_nxt = ST_PAUSE;
                end else if (w_lap) begin
                    w_nxt     = ST_LAP;
                    w_lap_cap = 1'b1;
                end
            end
            ST_LAP: begin
                if (w_limit) begin
                    w_nxt = ST_PAUSE;
                end else if (w_clr) begin
                    w_nxt = ST_LAP;
                end else if (w_ss) begin
                    w_nxt = ST_PAUSE;
                end else if (w_lap) begin
                    w_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (w_clr) begin
                    w_nxt    = ST_IDLE;
                    w_clr_go = 1'b1;
                end else if (w_ss) begin
                    w_nxt = ST_RUN;
                end
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_start_d = (w_nxt == ST_RUN) || (w_nxt == ST_LAP);
`ifdef LAP_EN
        w_hold_d  = (w_nxt == ST_LAP);
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_start <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_start <= w_start_d;
            r_clear <= w_clr_go;
        end
    end

`ifdef LAP_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lap_hold <= 1'b0;
            r_lap      <= '0;
        end else begin
            r_lap_hold <= w_hold_d;
            if (w_lap_cap) begin
                r_lap <= data_live;
            end
        end
    end

    assign lap_hold  = r_lap_hold;
    assign data_disp = r_lap_hold ? r_lap : data_live;
`else
    logic w_unused_cap;
    assign w_unused_cap = w_lap_cap;
    assign lap_hold  = 1'b0;
    assign data_disp = data_live;
`endif

    assign start_signal = r_start;
    assign clear_signal = r_clear;
    assign state_o      = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a 20-cycle debounce window.
// Handles builds with and without LAP_EN.
module tb_stopwatch_ctrl;

    localparam logic [19:0] CNT = 20'd19;
    // key low before P1: sync at P2, count reaches CNT at P(CNT+2),
    // flag in the following cycle, state registered at P(CNT+3)
    localparam int LAT = int'(CNT) + 3;

    typedef struct packed {
        logic [1:0]  st;
        logic        start;
        logic        clr;
        logic        hold;
        logic [15:0] disp;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        key_ss_n;
    logic        key_lap_n;
    logic        key_clr_n;
    logic [15:0] data_live;
    logic        start_signal;
    logic        clear_signal;
    logic [15:0] data_disp;
    logic        lap_hold;
    logic [1:0]  state_o;

    exp_t sb[$];
    exp_t e;
    exp_t o;
    int   n_chk;
    int   n_pass;
    int   chg;
    int   nclr;
    int   fclr;
    int   bad;

    stopwatch_ctrl #(.CNT_20MS(CNT), .DATA_LIMIT(16'd9999)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_ss_n     (key_ss_n),
        .key_lap_n    (key_lap_n),
        .key_clr_n    (key_clr_n),
        .data_live    (data_live),
        .start_signal (start_signal),
        .clear_signal (clear_signal),
        .data_disp    (data_disp),
        .lap_hold     (lap_hold),
        .state_o      (state_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic exp_t obs();
        exp_t r;
        r.st    = state_o;
        r.start = start_signal;
        r.clr   = clear_signal;
        r.hold  = lap_hold;
        r.disp  = data_disp;
        return r;
    endfunction

    function automatic exp_t mk(input logic [1:0] s, input logic h);
        exp_t r;
        r.st    = s;
        r.start = (s == 2'd1) || (s == 2'd3);
        r.clr   = 1'b0;
        r.hold  = h;
        r.disp  = data_live;
        return r;
    endfunction

    task automatic press(input logic ss, input logic lap, input logic clr,
                         output int c, output int nc, output int fc);
        logic [1:0] st0;
        st0 = state_o;
        c = 0;
        nc = 0;
        fc = 0;
        @(negedge sys_clk);
        key_ss_n  = ~ss;
        key_lap_n = ~lap;
        key_clr_n = ~clr;
        for (int i = 1; i <= 30; i++) begin
            @(posedge sys_clk);
            #1;
            if (clear_signal) begin
                nc++;
                if (fc == 0) fc = i;
            end
            if (c == 0 && state_o !== st0) c = i;
            if (i == 25) begin
                key_ss_n  = 1'b1;
                key_lap_n = 1'b1;
                key_clr_n = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_ss_n  = 1'b1;
        key_lap_n = 1'b1;
        key_clr_n = 1'b1;
        data_live = 16'd7;
        repeat (3) @(negedge sys_clk);
        sb.push_back(mk(2'd0, 1'b0));
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL reset_state: got %h want %h", o, e);
        else n_pass++;
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_bounce();
        bad = 0;
        @(negedge sys_clk);
        key_ss_n = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(posedge sys_clk);
            #1;
            if (state_o !== 2'd0 || start_signal !== 1'b0) bad++;
            if (i == 9) key_ss_n = 1'b1;
            if (i == 10) key_ss_n = 1'b0;
        end
        key_ss_n = 1'b1;
        repeat (5) begin
            @(posedge sys_clk);
            #1;
            if (state_o !== 2'd0 || start_signal !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL bounce_cycles: got %0d bad want 0", bad);
        else n_pass++;
        sb.push_back(mk(2'd0, 1'b0));
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL bounce_state: got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_ss_press();
        sb.push_back(mk(2'd1, 1'b0));
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
        n_chk++;
        if (chg !== LAT) $display("FAIL ss_latency: got %0d want %0d", chg, LAT);
        else n_pass++;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL ss_run: got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_lap();
`ifdef LAP_EN
        @(negedge sys_clk);
        data_live = 16'd42;
        sb.push_back(mk(2'd3, 1'b1));
        press(1'b0, 1'b1, 1'b0, chg, nclr, fclr);
        n_chk++;
        if (chg !== LAT) $display("FAIL lap_latency: got %0d want %0d", chg, LAT);
        else n_pass++;
        data_live = 16'd50;
        #1;
        e = sb.pop_front();
        e.disp = 16'd42;
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL lap_freeze: got %h want %h", o, e);
        else n_pass++;
        sb.push_back(mk(2'd1, 1'b0));
        press(1'b0, 1'b1, 1'b0, chg, nclr, fclr);
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL lap_release: got %h want %h", o, e);
        else n_pass++;
`else
        sb.push_back(mk(2'd1, 1'b0));
        press(1'b0, 1'b1, 1'b0, chg, nclr, fclr);
        n_chk++;
        if (chg !== 0) $display("FAIL lap_ignored_chg: got %0d want 0", chg);
        else n_pass++;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL lap_ignored: got %h want %h", o, e);
        else n_pass++;
`endif
    endtask

    task automatic test_clear();
        sb.push_back(mk(2'd2, 1'b0));
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL pause_state: got %h want %h", o, e);
        else n_pass++;
        sb.push_back(mk(2'd0, 1'b0));
        press(1'b0, 1'b0, 1'b1, chg, nclr, fclr);
        n_chk++;
        if (nclr !== 1) $display("FAIL clr_width: got %0d want 1", nclr);
        else n_pass++;
        n_chk++;
        if (fclr !== LAT) $display("FAIL clr_cycle: got %0d want %0d", fclr, LAT);
        else n_pass++;
        n_chk++;
        if (chg !== LAT) $display("FAIL clr_latency: got %0d want %0d", chg, LAT);
        else n_pass++;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL clr_idle: got %h want %h", o, e);
        else n_pass++;
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
        sb.push_back(mk(2'd1, 1'b0));
        press(1'b0, 1'b0, 1'b1, chg, nclr, fclr);
        n_chk++;
        if (nclr !== 0) $display("FAIL clr_in_run: got %0d pulses want 0", nclr);
        else n_pass++;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL clr_run_state: got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
        sb.push_back(mk(2'd0, 1'b0));
        press(1'b1, 1'b0, 1'b1, chg, nclr, fclr);
        n_chk++;
        if (nclr !== 1) $display("FAIL ss_clr_pulse: got %0d want 1", nclr);
        else n_pass++;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL ss_clr_state: got %h want %h", o, e);
        else n_pass++;
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
        @(negedge sys_clk);
        data_live = 16'd9999;
        sb.push_back(mk(2'd2, 1'b0));
        @(posedge sys_clk);
        #1;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL auto_stop: got %h want %h", o, e);
        else n_pass++;
        @(negedge sys_clk);
        data_live = 16'd100;
    endtask

    task automatic test_reset_mid();
        press(1'b1, 1'b0, 1'b0, chg, nclr, fclr);
`ifdef LAP_EN
        sb.push_back(mk(2'd3, 1'b1));
        press(1'b0, 1'b1, 1'b0, chg, nclr, fclr);
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL pre_rst_lap: got %h want %h", o, e);
        else n_pass++;
`endif
        @(negedge sys_clk);
        key_ss_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        sb.push_back(mk(2'd0, 1'b0));
        #1;
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL rst_immediate: got %h want %h", o, e);
        else n_pass++;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chg = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge sys_clk);
            #1;
            if (chg == 0 && state_o !== 2'd0) chg = i;
            if (i == 25) key_ss_n = 1'b1;
        end
        n_chk++;
        if (chg !== LAT) $display("FAIL rst_held_key: got %0d want %0d", chg, LAT);
        else n_pass++;
        sb.push_back(mk(2'd1, 1'b0));
        e = sb.pop_front();
        o = obs();
        n_chk++;
        if (o !== e) $display("FAIL rst_after_run: got %h want %h", o, e);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_bounce();
        test_ss_press();
        test_lap();
        test_clear();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
